bsg_wormhole_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter that lets `num_in_p` local wormhole sources share one router input link, typically the router's P input. A source is granted on a header flit and holds the link until its last body flit has handshaked, so packets are never interleaved. The datapath is a zero-latency mux. The only state is the grant lock, the remaining-flit counter and the round-robin pointer.

---
 rtl/bsg_wormhole_packet_arbiter_pkg.sv | 9 +
 rtl/bsg_wormhole_packet_arbiter_rr.sv | 63 ++++++
 rtl/bsg_wormhole_packet_arbiter.sv | 129 ++++++++++++
 tb/tb_bsg_wormhole_packet_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_wormhole_packet_arbiter_pkg.sv
// Shared types for the wormhole packet arbiter.
package bsg_wormhole_packet_arbiter_pkg;

    typedef enum logic [0:0] {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bsg_wormhole_packet_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from last grant + 1, pointer
// advances only when the grant is consumed (yumi_i).
module bsg_wormhole_packet_arbiter_rr #(
    parameter int inputs_p = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                grants_en_i,
    input  logic [inputs_p-1:0] reqs_i,
    output logic [inputs_p-1:0] grants_o,
    input  logic                yumi_i
);

    localparam int ptr_w_lp = $clog2(inputs_p);

    logic [ptr_w_lp-1:0] last_r;
    logic [ptr_w_lp-1:0] sel_idx_s;
    logic [ptr_w_lp:0]   cand_s;
    logic                found_s;

    // Wrap-around priority search starting just after the last winner
    always_comb begin
        sel_idx_s = last_r;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 1; k <= inputs_p; k++) begin
            cand_s = {1'b0, last_r} + (ptr_w_lp+1)'(k);
            if (cand_s >= (ptr_w_lp+1)'(inputs_p)) begin
                cand_s = cand_s - (ptr_w_lp+1)'(inputs_p);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && reqs_i[cand_s[ptr_w_lp-1:0]]) begin
                found_s   = 1'b1;
                sel_idx_s = cand_s[ptr_w_lp-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Decode the winning index into a one-hot grant
    always_comb begin
        grants_o = '0;
        if (found_s && grants_en_i) begin
            grants_o[sel_idx_s] = 1'b1;
        end else begin
            grants_o = '0;
        end
    end

    // Last-grant pointer; reset value gives source 0 top priority
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r <= ptr_w_lp'(inputs_p - 1);
        end else if (yumi_i) begin
            last_r <= sel_idx_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/bsg_wormhole_packet_arbiter.sv
// Packet-granular round-robin arbiter merging several wormhole sources onto one
// router link; a source keeps the link from header through its last body flit.
module bsg_wormhole_packet_arbiter
    import bsg_wormhole_packet_arbiter_pkg::*;
#(
    parameter int width_p          = 16,
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int len_width_p      = 4,
    parameter int reserved_width_p = 0,
    parameter int num_in_p         = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              v_i,
    input  logic [num_in_p-1:0][width_p-1:0] data_i,
    output logic [num_in_p-1:0]              ready_o,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             ready_i
);

    localparam int len_lsb_lp   = x_cord_width_p + y_cord_width_p;
    localparam int hdr_width_lp = len_lsb_lp + len_width_p + reserved_width_p;

    if (num_in_p < 2 || hdr_width_lp > width_p) begin : g_param_check
        $error("bsg_wormhole_packet_arbiter: illegal num_in_p or header wider than flit");
    end

    arb_state_e               state_r, state_n_s;
    logic [num_in_p-1:0]      owner_r, owner_n_s;
    logic [len_width_p-1:0]   count_r, count_n_s;
    logic [len_width_p-1:0]   len_s;
    logic [num_in_p-1:0]      reqs_s, grants_s, sel_oh_s;
    logic [width_p-1:0]       data_mux_s;
    logic                     hs_s, yumi_s;

    bsg_wormhole_packet_arbiter_rr #(
        .inputs_p (num_in_p)
    ) rr_arb (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .grants_en_i (1'b1),
        .reqs_i      (reqs_s),
        .grants_o    (grants_s),
        .yumi_i      (yumi_s)
    );

    // Request mask and output select: the owner alone is eligible while locked
    always_comb begin
        reqs_s   = v_i;
        sel_oh_s = grants_s;
        if (state_r == e_locked) begin
            reqs_s   = v_i & owner_r;
            sel_oh_s = owner_r;
        end else begin
            reqs_s   = v_i;
            sel_oh_s = grants_s;
        end
    end

    // One-hot data mux
    always_comb begin
        data_mux_s = '0;
        for (int i = 0; i < num_in_p; i++) begin
            if (sel_oh_s[i]) begin
                data_mux_s = data_mux_s | data_i[i];
            end else begin
                data_mux_s = data_mux_s;
            end
        end
    end

    assign data_o  = data_mux_s;
    assign v_o     = ~reset_i & (|reqs_s);
    assign ready_o = reset_i ? '0 : (sel_oh_s & {num_in_p{ready_i}});
    assign hs_s    = v_o & ready_i;
    assign len_s   = data_o[len_lsb_lp +: len_width_p];

    // Next lock/counter state and pointer-advance pulse on packet completion
    always_comb begin
        state_n_s = state_r;
        owner_n_s = owner_r;
        count_n_s = count_r;
        yumi_s    = 1'b0;
        case (state_r)
            e_idle: begin
                if (hs_s && (len_s == '0)) begin
                    yumi_s = 1'b1;
                end else if (hs_s) begin
                    owner_n_s = grants_s;
                    count_n_s = len_s;
                    state_n_s = e_locked;
                end else begin
                    state_n_s = e_idle;
                end
            end
            e_locked: begin
                if (hs_s && (count_r == len_width_p'(1))) begin
                    count_n_s = '0;
                    state_n_s = e_idle;
                    yumi_s    = 1'b1;
                end else if (hs_s) begin
                    count_n_s = count_r - len_width_p'(1);
                end else begin
                    count_n_s = count_r;
                end
            end
            default: begin
                state_n_s = e_idle;
                count_n_s = '0;
            end
        endcase
    end

    // Lock, owner and remaining-flit registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            owner_r <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_n_s;
            owner_r <= owner_n_s;
            count_r <= count_n_s;
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_packet_arbiter.sv
// Directed bench for the wormhole packet arbiter: 3 sources, 2-bit len field.
module tb_bsg_wormhole_packet_arbiter;

    localparam int W = 16;
    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [N-1:0]        v_i;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]        ready_o;
    logic                v_o;
    logic [W-1:0]        data_o;
    logic                ready_i;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] flits [N][8];
    int           nflits [N];
    int           idx [N];

    bsg_wormhole_packet_arbiter #(
        .width_p          (W),
        .x_cord_width_p   (4),
        .y_cord_width_p   (4),
        .len_width_p      (2),
        .reserved_width_p (0),
        .num_in_p         (N)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    // header: {payload[15:10], len[9:8], y[7:4], x[3:0]}
    function automatic logic [W-1:0] hdr(input int tag, input int len);
        return {6'(tag), 2'(len), 4'h3, 4'h5};
    endfunction

    // body flits carry len bits 2'b11 so any header decode of a body is visible
    function automatic logic [W-1:0] body(input int tag);
        return {6'(tag), 10'h3C5};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sources();
        for (int s = 0; s < N; s++) begin
            nflits[s] = 0;
            idx[s]    = 0;
        end
    endtask

    task automatic add_packet(input int s, input int len, input int tag0);
        flits[s][nflits[s]] = hdr(tag0, len);
        nflits[s]++;
        for (int b = 1; b <= len; b++) begin
            flits[s][nflits[s]] = body(tag0 + b);
            nflits[s]++;
        end
    endtask

    task automatic drive_sources(input logic [N-1:0] gap);
        for (int s = 0; s < N; s++) begin
            if (idx[s] < nflits[s] && !gap[s]) begin
                v_i[s]    = 1'b1;
                data_i[s] = flits[s][idx[s]];
            end else begin
                v_i[s]    = 1'b0;
                data_i[s] = '0;
            end
        end
    endtask

    task automatic advance_sources();
        for (int s = 0; s < N; s++) begin
            if (v_i[s] && ready_o[s] && ready_i) idx[s]++;
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        ready_i = 1'b1;
        v_i     = '0;
        data_i  = '0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i   = 1'b1;
        ready_i   = 1'b1;
        v_i       = 3'b111;
        data_i[0] = hdr(1, 0);
        data_i[1] = hdr(2, 0);
        data_i[2] = hdr(3, 0);
        #3;
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        checks++;
        if (ready_o !== 3'b000) begin errors++; $display("FAIL reset_ready_o got=%b exp=000", ready_o); end
        tick();
        reset_i = 1'b0;
        v_i     = '0;
        #3;
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle_v_o got=%b exp=0", v_o); end
        tick();
    endtask

    // Maximum len (3 with a 2-bit field) gives exactly 4 flits, then unlock
    task automatic test_single_source();
        do_reset();
        clear_sources();
        add_packet(0, 3, 0);
        for (int c = 0; c < 4; c++) begin
            drive_sources('0);
            #3;
            checks++;
            if (v_o !== 1'b1 || data_o !== flits[0][c] || ready_o !== 3'b001) begin
                errors++;
                $display("FAIL single_flit%0d got v=%b d=%h r=%b exp v=1 d=%h r=001", c, v_o, data_o, ready_o, flits[0][c]);
            end
            advance_sources();
            tick();
        end
        drive_sources('0);
        #3;
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL single_after_tail_v_o got=%b exp=0", v_o); end
        tick();
        add_packet(1, 0, 16);
        drive_sources('0);
        #3;
        checks++;
        if (ready_o !== 3'b010 || data_o !== hdr(16, 0)) begin
            errors++;
            $display("FAIL single_unlock got r=%b d=%h exp r=010 d=%h", ready_o, data_o, hdr(16, 0));
        end
        advance_sources();
        tick();
        v_i = '0;
    endtask

    task automatic test_no_interleave();
        logic [N-1:0] exp_r [5];
        int           exp_s [5];
        int           exp_k [5];
        exp_r = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
        exp_s = '{0, 0, 0, 1, 1};
        exp_k = '{0, 1, 2, 0, 1};
        do_reset();
        clear_sources();
        add_packet(0, 2, 0);
        add_packet(1, 1, 16);
        for (int c = 0; c < 5; c++) begin
            drive_sources('0);
            #3;
            checks++;
            if (ready_o !== exp_r[c] || data_o !== flits[exp_s[c]][exp_k[c]] || v_o !== 1'b1) begin
                errors++;
                $display("FAIL interleave_c%0d got r=%b d=%h exp r=%b d=%h", c, ready_o, data_o, exp_r[c], flits[exp_s[c]][exp_k[c]]);
            end
            advance_sources();
            tick();
        end
        v_i = '0;
    endtask

    task automatic test_fairness(input int len);
        int per;
        int src;
        per = len + 1;
        do_reset();
        clear_sources();
        for (int s = 0; s < N; s++) begin
            add_packet(s, len, s * 16);
            add_packet(s, len, s * 16 + 4);
        end
        for (int c = 0; c < 6 * per; c++) begin
            src = (c / per) % N;
            drive_sources('0);
            #3;
            checks++;
            if (ready_o !== (3'b001 << src) || data_o !== flits[src][idx[src]]) begin
                errors++;
                $display("FAIL fair_len%0d_c%0d got r=%b d=%h exp src=%0d d=%h", len, c, ready_o, data_o, src, flits[src][idx[src]]);
            end
            advance_sources();
            tick();
        end
        v_i = '0;
    endtask

    task automatic test_backpressure();
        logic [15:0]  rdy_pat;
        logic [15:0]  gap_pat;
        logic [N-1:0] gap;
        logic [W-1:0] exp_out [6];
        int           out_idx;
        rdy_pat = 16'b1101_1011_0111_0110;
        gap_pat = 16'b0100_1000_0010_0100;
        out_idx = 0;
        do_reset();
        clear_sources();
        add_packet(0, 3, 0);
        add_packet(1, 1, 16);
        for (int k = 0; k < 4; k++) exp_out[k] = flits[0][k];
        for (int k = 0; k < 2; k++) exp_out[4 + k] = flits[1][k];
        for (int c = 0; c < 40 && out_idx < 6; c++) begin
            ready_i = rdy_pat[c % 16];
            gap     = (idx[0] >= 1 && gap_pat[c % 16]) ? 3'b001 : 3'b000;
            drive_sources(gap);
            #3;
            if (out_idx >= 1 && out_idx <= 3) begin
                checks++;
                if (ready_o[1] !== 1'b0) begin errors++; $display("FAIL bp_lock_hold_c%0d got ready_o=%b exp bit1=0", c, ready_o); end
                if (gap[0]) begin
                    checks++;
                    if (v_o !== 1'b0) begin errors++; $display("FAIL bp_bubble_c%0d got v_o=%b exp=0", c, v_o); end
                end
            end
            if (v_o && ready_i) begin
                checks++;
                if (data_o !== exp_out[out_idx]) begin
                    errors++;
                    $display("FAIL bp_flit%0d got=%h exp=%h", out_idx, data_o, exp_out[out_idx]);
                end
                out_idx++;
            end
            advance_sources();
            tick();
        end
        checks++;
        if (out_idx != 6) begin errors++; $display("FAIL bp_flit_count got=%0d exp=6", out_idx); end
        checks++;
        if (idx[0] != 4 || idx[1] != 2) begin
            errors++;
            $display("FAIL bp_consumed got src0=%0d src1=%0d exp 4 2", idx[0], idx[1]);
        end
        ready_i = 1'b1;
        v_i     = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        clear_sources();
        add_packet(0, 3, 0);
        for (int c = 0; c < 2; c++) begin
            drive_sources('0);
            #3;
            advance_sources();
            tick();
        end
        drive_sources('0);
        reset_i = 1'b1;
        #3;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 3'b000) begin
            errors++;
            $display("FAIL midreset_during got v=%b r=%b exp v=0 r=000", v_o, ready_o);
        end
        tick();
        reset_i = 1'b0;
        v_i     = '0;
        #3;
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL midreset_next_v_o got=%b exp=0", v_o); end
        tick();
        v_i       = 3'b010;
        data_i[1] = hdr(20, 0);
        ready_i   = 1'b0;
        #3;
        checks++;
        if (v_o !== 1'b1 || data_o !== hdr(20, 0)) begin
            errors++;
            $display("FAIL midreset_no_stale_lock got v=%b d=%h exp v=1 d=%h", v_o, data_o, hdr(20, 0));
        end
        tick();
        v_i       = 3'b011;
        data_i[0] = hdr(21, 0);
        ready_i   = 1'b1;
        #3;
        checks++;
        if (ready_o !== 3'b001 || data_o !== hdr(21, 0)) begin
            errors++;
            $display("FAIL midreset_src0_first got r=%b d=%h exp r=001 d=%h", ready_o, data_o, hdr(21, 0));
        end
        tick();
        v_i = 3'b010;
        #3;
        checks++;
        if (ready_o !== 3'b010 || data_o !== hdr(20, 0)) begin
            errors++;
            $display("FAIL midreset_src1_next got r=%b d=%h exp r=010 d=%h", ready_o, data_o, hdr(20, 0));
        end
        tick();
        v_i = '0;
    endtask

    initial begin
        reset_i = 1'b1;
        ready_i = 1'b1;
        v_i     = '0;
        data_i  = '0;
        test_reset();
        test_single_source();
        test_no_interleave();
        test_fairness(0);
        test_fairness(1);
        test_backpressure();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
